// File: rtl/uart_rx_if.sv
// Byte-side handshake between the UART receiver and the bus-side peripheral wrapper.
// master = receiver (produces bytes and status pulses), slave = consumer.
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rx_data_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  modport master (
    output rx_data, rx_data_valid, frame_err, overrun, busy,
    input  rx_data_ready
  );

  modport slave (
    input  rx_data, rx_data_valid, frame_err, overrun, busy,
    output rx_data_ready
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronised input, mid-bit sampling, stop-bit check,
// valid/ready byte delivery with one-cycle frame_err / overrun pulses.
module uart_rx #(
  parameter int CLK_FREQUENCY = 50,
  parameter int BAUD_RATE     = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_pin,
  uart_rx_if.master   bus
);
  localparam int CYCLE = CLK_FREQUENCY * 1000000 / BAUD_RATE;
  localparam int HALF  = CYCLE / 2;
  localparam logic [15:0] HALF_M1  = 16'(HALF - 1);
  localparam logic [15:0] CYCLE_M1 = 16'(CYCLE - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t      state;
  logic [15:0] cycle_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_reg;
  logic        rx_meta, rx_sync, rx_sync_d;

  // Reset to the idle level so leaving reset never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_sync_d <= 1'b1;
    end else begin
      rx_meta   <= rx_pin;
      rx_sync   <= rx_meta;
      rx_sync_d <= rx_sync;
    end
  end

  assign bus.busy = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= S_IDLE;
      cycle_cnt         <= '0;
      bit_cnt           <= '0;
      shift_reg         <= '0;
      bus.rx_data       <= '0;
      bus.rx_data_valid <= 1'b0;
      bus.frame_err     <= 1'b0;
      bus.overrun       <= 1'b0;
    end else begin
      bus.frame_err <= 1'b0;
      bus.overrun   <= 1'b0;
      if (bus.rx_data_valid && bus.rx_data_ready)
        bus.rx_data_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          cycle_cnt <= '0;
          bit_cnt   <= '0;
          // Edge-triggered so a held-low break line cannot restart a frame.
          if (rx_sync_d && !rx_sync)
            state <= S_START;
        end
        S_START: begin
          if (cycle_cnt == HALF_M1 && rx_sync) begin
            state     <= S_IDLE;
            cycle_cnt <= '0;
          end else if (cycle_cnt == CYCLE_M1) begin
            state     <= S_DATA;
            cycle_cnt <= '0;
          end else begin
            cycle_cnt <= cycle_cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (cycle_cnt == HALF_M1)
            shift_reg[bit_cnt] <= rx_sync;
          if (cycle_cnt == CYCLE_M1) begin
            cycle_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              state   <= S_STOP;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            cycle_cnt <= cycle_cnt + 16'd1;
          end
        end
        S_STOP: begin
          // Leave at mid-stop so a back-to-back start edge is not missed.
          if (cycle_cnt == HALF_M1) begin
            state     <= S_IDLE;
            cycle_cnt <= '0;
            if (rx_sync) begin
              bus.rx_data       <= shift_reg;
              bus.rx_data_valid <= 1'b1;
              bus.overrun       <= bus.rx_data_valid && !bus.rx_data_ready;
            end else begin
              bus.frame_err <= 1'b1;
            end
          end else begin
            cycle_cnt <= cycle_cnt + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: drives serial frames at CYCLE clocks/bit and
// compares delivered bytes, flag pulses and timing against a frame-level model.
module tb_uart_rx;
  localparam int CYCLE = 50 * 1000000 / 115200;
  localparam int HALF  = CYCLE / 2;
  localparam int LAT   = 3 + 9 * CYCLE + HALF;  // pin fall -> first valid cycle
  localparam int FBUSY = 9 * CYCLE + HALF;      // busy cycles of one full frame

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_pin = 1'b1;
  uart_rx_if bus ();

  uart_rx #(.CLK_FREQUENCY(50), .BAUD_RATE(115200)) dut (
    .clk(clk), .rst(rst), .rx_pin(rx_pin), .bus(bus)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: event counters and accepted-byte log, sampled away from the edge.
  int nrise = 0, nvalid = 0, nbusy = 0, nferr = 0, novr = 0, nboth = 0;
  int rise_cyc = 0;
  logic prev_valid = 1'b0;
  logic [7:0] acc_q[$];
  always @(negedge clk) begin
    if (bus.rx_data_valid && !prev_valid) begin
      nrise++;
      rise_cyc = cyc;
    end
    prev_valid = bus.rx_data_valid;
    if (bus.rx_data_valid) nvalid++;
    if (bus.rx_data_valid && bus.rx_data_ready) acc_q.push_back(bus.rx_data);
    if (bus.busy) nbusy++;
    if (bus.frame_err) nferr++;
    if (bus.overrun) novr++;
    if (bus.frame_err && bus.overrun) nboth++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, output int fall);
    rx_pin = 1'b0;
    fall = cyc;
    tick(CYCLE);
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      tick(CYCLE);
    end
    rx_pin = stop;
    tick(CYCLE);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (bus.rx_data !== 8'h00 || bus.rx_data_valid !== 1'b0 || bus.frame_err !== 1'b0 ||
        bus.overrun !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: data=%h valid=%b ferr=%b ovr=%b busy=%b, want all 0",
               bus.rx_data, bus.rx_data_valid, bus.frame_err, bus.overrun, bus.busy);
    end
    tick(5);
    rst = 1'b0;
    tick(5);
  endtask

  task automatic test_single();
    int fall, r0, v0, b0, f0, o0, a0;
    r0 = nrise; v0 = nvalid; b0 = nbusy; f0 = nferr; o0 = novr; a0 = acc_q.size();
    send_frame(8'h55, 1'b1, fall);
    tick(4);
    checks++;
    if (nrise - r0 !== 1 || rise_cyc !== fall + LAT) begin
      errors++;
      $display("FAIL single_latency: rises=%0d at cyc %0d, want 1 at %0d", nrise - r0, rise_cyc, fall + LAT);
    end
    checks++;
    if (nvalid - v0 !== 1) begin
      errors++;
      $display("FAIL single_valid_width: valid high %0d cycles, want 1", nvalid - v0);
    end
    checks++;
    if (acc_q.size() !== a0 + 1 || (acc_q.size() > a0 && acc_q[a0] !== 8'h55)) begin
      errors++;
      $display("FAIL single_data: accepted %0d bytes, want one 0x55", acc_q.size() - a0);
    end
    checks++;
    if (nbusy - b0 !== FBUSY || nferr !== f0 || novr !== o0) begin
      errors++;
      $display("FAIL single_busy_flags: busy=%0d ferr=%0d ovr=%0d, want %0d 0 0",
               nbusy - b0, nferr - f0, novr - o0, FBUSY);
    end
  endtask

  task automatic test_back_to_back();
    int fall, b0, f0, a0;
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'hA3;
    b0 = nbusy; f0 = nferr; a0 = acc_q.size();
    for (int i = 0; i < 3; i++) send_frame(exp_b[i], 1'b1, fall);
    tick(4);
    checks++;
    if (acc_q.size() !== a0 + 3) begin
      errors++;
      $display("FAIL b2b_count: accepted %0d bytes, want 3", acc_q.size() - a0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (acc_q[a0 + i] !== exp_b[i]) begin
          errors++;
          $display("FAIL b2b_data[%0d]: got %h want %h", i, acc_q[a0 + i], exp_b[i]);
        end
      end
    end
    checks++;
    if (nferr !== f0 || nbusy - b0 !== 3 * FBUSY) begin
      errors++;
      $display("FAIL b2b_flags: ferr=%0d busy=%0d, want 0 %0d", nferr - f0, nbusy - b0, 3 * FBUSY);
    end
  endtask

  task automatic test_glitch();
    int fall, r0, b0, f0, o0, a0;
    r0 = nrise; b0 = nbusy; f0 = nferr; o0 = novr;
    rx_pin = 1'b0;
    tick(100);
    rx_pin = 1'b1;
    tick(CYCLE);
    checks++;
    if (nbusy - b0 !== HALF || nrise !== r0 || nferr !== f0 || novr !== o0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_reject: busy=%0d rises=%0d ferr=%0d ovr=%0d, want %0d 0 0 0",
               nbusy - b0, nrise - r0, nferr - f0, novr - o0, HALF);
    end
    a0 = acc_q.size();
    send_frame(8'h3C, 1'b1, fall);
    tick(4);
    checks++;
    if (acc_q.size() !== a0 + 1 || (acc_q.size() > a0 && acc_q[a0] !== 8'h3C)) begin
      errors++;
      $display("FAIL glitch_followup: accepted %0d bytes, want one 0x3C", acc_q.size() - a0);
    end
  endtask

  task automatic test_break();
    int fall, r0, b0, f0, o0;
    r0 = nrise; b0 = nbusy; f0 = nferr; o0 = novr;
    send_frame(8'h81, 1'b0, fall);
    tick(20 * CYCLE);
    checks++;
    if (nferr - f0 !== 1 || nboth !== 0 || novr !== o0) begin
      errors++;
      $display("FAIL break_ferr: ferr pulses=%0d ovr=%0d, want 1 0", nferr - f0, novr - o0);
    end
    checks++;
    if (nrise !== r0 || bus.rx_data_valid !== 1'b0 || nbusy - b0 !== FBUSY) begin
      errors++;
      $display("FAIL break_no_retrigger: rises=%0d valid=%b busy=%0d, want 0 0 %0d",
               nrise - r0, bus.rx_data_valid, nbusy - b0, FBUSY);
    end
    rx_pin = 1'b1;
    tick(CYCLE);
  endtask

  task automatic test_overrun();
    int fall, r0, o0, a0;
    bus.rx_data_ready = 1'b0;
    r0 = nrise; o0 = novr; a0 = acc_q.size();
    send_frame(8'h12, 1'b1, fall);
    tick(4);
    checks++;
    if (bus.rx_data_valid !== 1'b1 || bus.rx_data !== 8'h12) begin
      errors++;
      $display("FAIL ovr_hold: valid=%b data=%h, want 1 12", bus.rx_data_valid, bus.rx_data);
    end
    send_frame(8'h34, 1'b1, fall);
    tick(4);
    checks++;
    if (bus.rx_data !== 8'h34 || bus.rx_data_valid !== 1'b1 || novr - o0 !== 1 || nrise - r0 !== 1) begin
      errors++;
      $display("FAIL ovr_pulse: data=%h valid=%b ovr=%0d rises=%0d, want 34 1 1 1",
               bus.rx_data, bus.rx_data_valid, novr - o0, nrise - r0);
    end
    bus.rx_data_ready = 1'b1;
    tick(1);
    checks++;
    if (bus.rx_data_valid !== 1'b0 || acc_q.size() !== a0 + 1 ||
        (acc_q.size() > a0 && acc_q[a0] !== 8'h34)) begin
      errors++;
      $display("FAIL ovr_release: valid=%b accepted=%0d, want 0 and one 0x34",
               bus.rx_data_valid, acc_q.size() - a0);
    end
  endtask

  task automatic test_reset_midframe();
    int fall, f0, o0, a0;
    logic [7:0] b;
    b = 8'hC9;
    rx_pin = 1'b0;
    tick(CYCLE);
    for (int i = 0; i < 4; i++) begin
      rx_pin = b[i];
      tick(CYCLE);
    end
    rx_pin = b[4];
    tick(HALF);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.rx_data !== 8'h00 || bus.rx_data_valid !== 1'b0 || bus.frame_err !== 1'b0 ||
        bus.overrun !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_midframe: data=%h valid=%b ferr=%b ovr=%b busy=%b, want all 0",
               bus.rx_data, bus.rx_data_valid, bus.frame_err, bus.overrun, bus.busy);
    end
    rx_pin = 1'b1;
    tick(5);
    rst = 1'b0;
    tick(5);
    f0 = nferr; o0 = novr; a0 = acc_q.size();
    send_frame(8'h7E, 1'b1, fall);
    tick(4);
    checks++;
    if (acc_q.size() !== a0 + 1 || (acc_q.size() > a0 && acc_q[a0] !== 8'h7E) ||
        nferr !== f0 || novr !== o0) begin
      errors++;
      $display("FAIL reset_recover: accepted=%0d ferr=%0d ovr=%0d, want one 0x7E and no flags",
               acc_q.size() - a0, nferr - f0, novr - o0);
    end
  endtask

  task automatic test_random();
    int fall, f0, a0, exp_ferr;
    logic [7:0] b;
    logic stop;
    logic [7:0] exp_q[$];
    f0 = nferr; a0 = acc_q.size(); exp_ferr = 0;
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      send_frame(b, stop, fall);
      if (stop) exp_q.push_back(b);
      else begin
        exp_ferr++;
        rx_pin = 1'b1;
        tick(CYCLE);
      end
    end
    tick(4);
    checks++;
    if (nferr - f0 !== exp_ferr || acc_q.size() - a0 !== exp_q.size()) begin
      errors++;
      $display("FAIL random_counts: ferr=%0d bytes=%0d, want %0d %0d",
               nferr - f0, acc_q.size() - a0, exp_ferr, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (acc_q[a0 + i] !== exp_q[i]) begin
          errors++;
          $display("FAIL random_data[%0d]: got %h want %h", i, acc_q[a0 + i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    bus.rx_data_ready = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_break();
    test_overrun();
    test_reset_midframe();
    test_random();
    checks++;
    if (nboth !== 0) begin
      errors++;
      $display("FAIL flags_exclusive: %0d cycles with frame_err and overrun both high, want 0", nboth);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
